// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys 10..0 requested from an external key store.
// Optional abort input enabled by defining INV_CIPHER_ABORT_EN.
module aes_inv_cipher #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef INV_CIPHER_ABORT_EN
  input  logic                  abort_in,
`endif
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] text_0_in,
  input  logic [DATA_WIDTH-1:0] text_1_in,
  input  logic [DATA_WIDTH-1:0] text_2_in,
  input  logic [DATA_WIDTH-1:0] text_3_in,
  input  logic [DATA_WIDTH-1:0] key_0_in,
  input  logic [DATA_WIDTH-1:0] key_1_in,
  input  logic [DATA_WIDTH-1:0] key_2_in,
  input  logic [DATA_WIDTH-1:0] key_3_in,
  output logic [3:0]            key_round_out,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] text_0_out,
  output logic [DATA_WIDTH-1:0] text_1_out,
  output logic [DATA_WIDTH-1:0] text_2_out,
  output logic [DATA_WIDTH-1:0] text_3_out,
  output logic                  decipher_dv_flag
);

  localparam int unsigned STATE_W    = 4 * DATA_WIDTH;
  localparam int unsigned LAST_ROUND = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ROUND = 3'b011,
    DONE  = 3'b100
  } fsm_t;

  fsm_t               fsm;
  logic [3:0]         count;
  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] out_q;
  logic [STATE_W-1:0] rk;
  logic [STATE_W-1:0] sb;
  logic [STATE_W-1:0] ark;
  logic [STATE_W-1:0] mix;
  logic [STATE_W-1:0] rnd_next;
  logic               abort;

`ifdef INV_CIPHER_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x120, x126;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x120 = gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15)));
    x126 = gmul(x120, x6);
    return gmul(gmul(x126, x126), x2);
  endfunction

  // Inverse S-box: undo the affine transform, then invert in GF(2^8)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = inv_sbox(s[127-32*((c+4-r)%4)-8*r -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Round datapath: initial AddRoundKey, middle rounds, final round without InvMixColumns
  always_comb begin
    rk  = {key_0_in, key_1_in, key_2_in, key_3_in};
    sb  = inv_shift_sub(st);
    ark = sb ^ rk;
    mix = inv_mix_columns(ark);
    if (count == 4'd0)
      rnd_next = st ^ rk;
    else if (count == 4'(LAST_ROUND))
      rnd_next = ark;
    else
      rnd_next = mix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm              <= IDLE;
      count            <= '0;
      st               <= '0;
      out_q            <= '0;
      key_round_out    <= 4'(LAST_ROUND);
      busy_out         <= 1'b0;
      decipher_dv_flag <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start_in) begin
            st       <= {text_0_in, text_1_in, text_2_in, text_3_in};
            count    <= '0;
            busy_out <= 1'b1;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            st            <= '0;
            count         <= '0;
            key_round_out <= 4'(LAST_ROUND);
            busy_out      <= 1'b0;
            fsm           <= IDLE;
          end else begin
            st <= rnd_next;
            if (count == 4'(LAST_ROUND)) begin
              out_q            <= rnd_next;
              decipher_dv_flag <= 1'b1;
              key_round_out    <= 4'(LAST_ROUND);
              fsm              <= DONE;
            end else begin
              count         <= count + 4'd1;
              key_round_out <= key_round_out - 4'd1;
            end
          end
        end
        DONE: begin
          out_q            <= '0;
          decipher_dv_flag <= 1'b0;
          busy_out         <= 1'b0;
          fsm              <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign text_0_out = out_q[127:96];
  assign text_1_out = out_q[95:64];
  assign text_2_out = out_q[63:32];
  assign text_3_out = out_q[31:0];

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: a key-store model feeds round keys, a cycle model checks control outputs,
// and a scoreboard queue holds expected plaintexts. Covers INV_CIPHER_ABORT_EN when defined.
module tb_aes_inv_cipher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] t0, t1, t2, t3;
  logic [31:0] k0, k1, k2, k3;
  logic [3:0]  key_round;
  logic        busy;
  logic [31:0] o0, o1, o2, o3;
  logic        dv;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          active = 1'b0;
  bit          mon_en = 1'b0;
  logic [127:0] cur_exp;
  logic [127:0] sbq[$];
  logic [31:0]  ks[44];

  localparam logic [127:0] C1_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] C1_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] B_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8_885a308d_313198a2_e0370734;

  always #5 clk = ~clk;

  aes_inv_cipher #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef INV_CIPHER_ABORT_EN
    .abort_in         (abort),
`endif
    .start_in         (start),
    .text_0_in        (t0),
    .text_1_in        (t1),
    .text_2_in        (t2),
    .text_3_in        (t3),
    .key_0_in         (k0),
    .key_1_in         (k1),
    .key_2_in         (k2),
    .key_3_in         (k3),
    .key_round_out    (key_round),
    .busy_out         (busy),
    .text_0_out       (o0),
    .text_1_out       (o1),
    .text_2_out       (o2),
    .text_3_out       (o3),
    .decipher_dv_flag (dv)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Key-store model: forward S-box and AES-128 key expansion
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = 8'h00;
    for (int i = 1; i < 256; i++)
      if (mul(x, 8'(i)) == 8'h01) b = 8'(i);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) ks[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = ks[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]) ^ rcon, sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])};
        rcon = mul(rcon, 8'h02);
      end
      ks[i] = ks[i-4] ^ tmp;
    end
  endtask

  always_comb begin
    k0 = ks[4*int'(key_round) + 0];
    k1 = ks[4*int'(key_round) + 1];
    k2 = ks[4*int'(key_round) + 2];
    k3 = ks[4*int'(key_round) + 3];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle model of control outputs plus scoreboard; inputs sampled here decide the next cycle
  always @(negedge clk) begin
    int d;
    logic [127:0] exp_pt;
    if (mon_en) begin
      d = cyc - start_cyc;
      check("busy", 128'(busy), 128'(active && d >= 1 && d <= 12));
      check("key_round", 128'(key_round), 128'((active && d >= 1 && d <= 11) ? 11 - d : 10));
      check("dv", 128'(dv), 128'(active && d == 12));
      if (active && d == 12) begin
        exp_pt = sbq.pop_front();
        check("plaintext", {o0, o1, o2, o3}, exp_pt);
      end else begin
        check("text_idle_zero", {o0, o1, o2, o3}, 128'h0);
      end
      if (rst) begin
        active = 1'b0;
        sbq.delete();
      end else if (active && d == 12) begin
        active = 1'b0;
`ifdef INV_CIPHER_ABORT_EN
      end else if (active && abort && d >= 1 && d <= 11) begin
        active = 1'b0;
        void'(sbq.pop_back());
`endif
      end else if (active && d == 0) begin
        active = 1'b1;
      end else if (!active && start) begin
        active    = 1'b1;
        start_cyc = cyc;
        sbq.push_back(cur_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick(1);
      n++;
    end
    check("idle_wait", 128'(busy), 128'h0);
  endtask

  task automatic launch(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
    expand(key);
    cur_exp = pt;
    {t0, t1, t2, t3} = ct;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    {t0, t1, t2, t3} = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    {t0, t1, t2, t3} = '0;
    expand(C1_KEY);
    cur_exp = C1_PT;
    check("rk10_model", {ks[40], ks[41], ks[42], ks[43]}, 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);
    tick(1);
    mon_en = 1'b1;
    start  = 1'b1;
    tick(2);
    rst   = 1'b0;
    start = 1'b0;
    tick(2);

    launch(C1_CT, C1_KEY, C1_PT);
    wait_idle();
    tick(2);
    launch(B_CT, B_KEY, B_PT);
    wait_idle();

    // Held start: back-to-back blocks every 13 cycles
    expand(C1_KEY);
    cur_exp = C1_PT;
    {t0, t1, t2, t3} = C1_CT;
    start = 1'b1;
    tick(40);
    start = 1'b0;
    wait_idle();

    // Stray start pulse mid-ROUND
    launch(B_CT, B_KEY, B_PT);
    tick(4);
    {t0, t1, t2, t3} = C1_CT;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle();
    tick(1);

    // Reset at ROUND c=5, then a clean run
    launch(C1_CT, C1_KEY, C1_PT);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    launch(C1_CT, C1_KEY, C1_PT);
    wait_idle();

`ifdef INV_CIPHER_ABORT_EN
    // Abort at c=3, then abort held through an IDLE start
    launch(B_CT, B_KEY, B_PT);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);
    abort = 1'b1;
    launch(B_CT, B_KEY, B_PT);
    abort = 1'b0;
    wait_idle();
`endif

    tick(3);
    check("scoreboard_drained", 128'(sbq.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
